// File: rtl/ifu_fetch_ctrl.sv
// rtl/ifu_fetch_ctrl.sv - instruction-fetch controller: PC, icache request/hold, redirect and fence.i sequencing
// Optional performance counters enabled by defining IFU_FETCH_PERF_EN.
module ifu_fetch_ctrl #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h3000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] icache_addr,
  output logic                  icache_req,
  input  logic [DATA_WIDTH-1:0] icache_data,
  input  logic                  icache_valid,
  output logic                  icache_fence_i,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  fence_i,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc
`ifdef IFU_FETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_miss_cnt,
  output logic [31:0]           perf_wait_cycles
`endif
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  discard;
  logic                  fence_pend;
  logic [ADDR_WIDTH-1:0] redir_pc_al;

  assign redir_pc_al    = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  // A pending fence steals the FETCH cycle so it never overlaps an in-flight miss.
  assign icache_req     = !rst && (state == S_FETCH) && !fence_pend;
  assign icache_fence_i = !rst && (state == S_FETCH) && fence_pend;
  assign icache_addr    = (state == S_FETCH) ? pc : addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      addr_q     <= RESET_PC;
      discard    <= 1'b0;
      fence_pend <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
    end else begin
      fence_pend <= fence_pend | fence_i;
      if (redirect_valid) pc <= redir_pc_al;
      case (state)
        S_FETCH: begin
          if (fence_pend) begin
            fence_pend <= fence_i;
          end else begin
            addr_q <= pc;
            if (icache_valid && !redirect_valid) begin
              inst       <= icache_data;
              inst_pc    <= pc;
              inst_valid <= 1'b1;
              pc         <= pc + ADDR_WIDTH'(4);
              state      <= S_HOLD;
            end else if (!icache_valid) begin
              // Miss already launched; a redirect now must drop its response.
              discard <= redirect_valid;
              state   <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (icache_valid) begin
            discard <= 1'b0;
            state   <= S_FETCH;
            if (!discard && !redirect_valid) begin
              inst       <= icache_data;
              inst_pc    <= addr_q;
              inst_valid <= 1'b1;
              pc         <= addr_q + ADDR_WIDTH'(4);
              state      <= S_HOLD;
            end
          end else if (redirect_valid) begin
            discard <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect_valid || inst_ready) begin
            inst_valid <= 1'b0;
            state      <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

`ifdef IFU_FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt   <= '0;
      perf_miss_cnt    <= '0;
      perf_wait_cycles <= '0;
    end else begin
      if (icache_req) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (icache_req && !icache_valid) perf_miss_cnt <= perf_miss_cnt + 32'd1;
      if (state == S_WAIT) perf_wait_cycles <= perf_wait_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: doc/ifu_fetch_ctrl.md
Name: ifu_fetch_ctrl

Overview:
- Instruction-fetch controller sitting directly upstream of the icache. It owns the PC and issues one-cycle fetch requests to the icache.
- It holds the fetch address stable until the icache returns valid, then buffers the returned word for decode (IDU) behind a valid/ready handshake.
- It handles redirects (branch/jump/trap) and fence.i sequencing, including discarding responses that become stale while an icache miss is in flight.

Parameters:
- RESET_PC, 32'h3000_0000, PC loaded on reset.
- ADDR_WIDTH, 32, fetch address width.
- DATA_WIDTH, 32, instruction width.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; asynchronous, active-high.
- icache_addr  out  ADDR_WIDTH  fetch address to icache; stable from req until icache_valid.
- icache_req  out  1  one-cycle fetch request.
- icache_data  in  DATA_WIDTH  instruction word from icache.
- icache_valid  in  1  icache data valid; may be asserted in the same cycle as req (hit) or later (miss).
- icache_fence_i  out  1  one-cycle icache invalidate.
- redirect_valid  in  1  redirect request from the back end.
- redirect_pc  in  ADDR_WIDTH  redirect target.
- fence_i  in  1  fence.i request pulse from the back end.
- inst_valid  out  1  buffered instruction valid toward IDU.
- inst_ready  in  1  IDU accepts.
- inst  out  DATA_WIDTH  instruction.
- inst_pc  out  ADDR_WIDTH  PC of inst.

Behaviour:
- Registers:
  - pc (next fetch PC).
  - addr_q (in-flight address; drives icache_addr).
  - discard (drop next response).
  - fence_pend.
  - out buffer (inst, inst_pc, inst_valid).
  - state: FETCH / WAIT / HOLD.
- Reset (async, rst=1):
  - state=FETCH, pc=RESET_PC, addr_q=RESET_PC.
  - discard=0, fence_pend=0.
  - inst_valid=0, inst=0, inst_pc=0.
  - icache_req=0 and icache_fence_i=0 while rst=1.
  - First req occurs in the first cycle after rst deasserts.
  - Reset mid-miss simply abandons the transaction; the icache is reset by the same system.
- FETCH:
  - If fence_pend: icache_fence_i=1, icache_req=0, clear fence_pend, stay FETCH.
  - Else: icache_req=1, icache_addr=pc (combinational), addr_q<=pc.
  - If icache_valid in the same cycle: capture icache_data and pc into the out buffer, pc<=pc+4, go to HOLD. Fetch-to-inst_valid latency on a hit is 1 cycle.
  - Otherwise: go to WAIT.
- WAIT:
  - icache_req=0; icache_addr=addr_q held constant (the icache uses it for the word offset).
  - On icache_valid with discard=1: drop the word, discard<=0, go to FETCH.
  - On icache_valid with discard=0: capture into the out buffer with inst_pc=addr_q, pc<=addr_q+4, go to HOLD.
- HOLD:
  - inst_valid=1; outputs stable until the handshake.
  - On inst_valid&&inst_ready: inst_valid<=0, go to FETCH.
  - At most one instruction is outstanding; no prefetch.
- Redirect (highest priority; low 2 bits of redirect_pc forced to 0):
  - pc<=redirect_pc in every state.
  - FETCH with icache_valid in the same cycle: the response is not captured; stay FETCH.
  - FETCH without icache_valid: the miss has been launched, so set discard=1 and go to WAIT.
  - WAIT: set discard=1 unless icache_valid is in the same cycle, in which case drop the response and go to FETCH. addr_q is unchanged.
  - HOLD: inst_valid<=0 and go to FETCH. If inst_ready coincides, the instruction counts as consumed and the redirect still wins the PC.
- fence_i:
  - Sets fence_pend; it is OR-merged if already pending.
  - The fence is issued only from FETCH, so it never overlaps an in-flight miss.
  - fence_i together with redirect_valid is legal: both take effect, and the fence is issued before the first fetch at redirect_pc.
- PC arithmetic: modulo 2^ADDR_WIDTH; 32'hFFFF_FFFC+4 wraps to 0.
- icache_valid outside FETCH/WAIT: ignored.

Optional Feature:
- Macro IFU_FETCH_PERF_EN.
- When defined, adds three 32-bit outputs, each reset to 0 and wrapping:
  - perf_fetch_cnt: +1 per icache_req.
  - perf_miss_cnt: +1 per FETCH→WAIT transition.
  - perf_wait_cycles: +1 per cycle in WAIT.
- When undefined, these ports and their counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, icache hits every req, inst_ready=1 → req at cycle 1 with addr 0x3000_0000; inst_pc sequence 0x3000_0000, 0x3000_0004, … with one instruction every 2 cycles.
- Miss, valid returned 10 cycles after req → icache_addr held at 0x3000_0000 for all 10 cycles with req low after the first cycle; inst_pc=0x3000_0000; next req at 0x3000_0004.
- Redirect to 0x3000_0100 in the 3rd WAIT cycle of a miss → the miss response is dropped, inst_valid never rises for it, and the next req is at 0x3000_0100.
- HOLD with inst_ready=0 for 5 cycles → inst and inst_pc stable, no req; ready=1 → next req the following cycle.
- fence_i together with redirect to 0x3000_0200 while in WAIT → after valid, one cycle with icache_fence_i=1 and req=0, then req at 0x3000_0200.
- Redirect_pc=0x3000_0103 → next req at 0x3000_0100; pc at 0xFFFF_FFFC with a hit → next req at 0x0000_0000.
